irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Parametrised multi-source interrupt controller in front of the CP0 single-bit external interrupt input.
- Synchronises up to N_CH asynchronous sources and applies per-channel level/edge mode and mask.
- Arbitrates by fixed priority (lowest index wins) and drives one request line into CP0.
- Tracks the in-service channel through an ack/EOI handshake with the core; software configures it through a small word-addressed register port.

Parameters:
N_CH, 8, number of interrupt sources (1..32)
SYNC_STAGES, 2, flip-flop stages per input synchroniser (>=2)
ID_W, 5, width of channel id output (must satisfy 2^ID_W >= N_CH)

Ports:
clk  in  1  main clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
irq_in  in  N_CH  raw asynchronous interrupt sources
ir_out  out  1  interrupt request to CP0 ir_in
ack  in  1  core accepted interrupt (CP0 force jump taken), one-cycle pulse
eoi  in  1  end of interrupt (ERET retired), one-cycle pulse
irq_id  out  ID_W  channel id latched at ack
irq_id_valid  out  1  irq_id refers to a channel currently in service
cfg_wen  in  1  register write strobe
cfg_addr  in  2  register select
cfg_din  in  32  register write data
cfg_dout  out  32  register read data, combinational from cfg_addr

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; MASK=0, MODE=0, PENDING=0; synchronisers and edge history=0; ir_out=0, irq_id=0, irq_id_valid=0.
- Synchroniser: each irq_in bit passes through SYNC_STAGES flops giving s[i]; prev[i] holds s[i] delayed one cycle.
- Raw request r[i]:
  - MODE[i]=0 (level): r[i]=s[i]; not stored.
  - MODE[i]=1 (edge): PENDING[i] sets on s[i]&~prev[i]; r[i]=PENDING[i].
- Enabled request: e = r & MASK. Winner = lowest index i with e[i]=1.
- Registers (bits >= N_CH read 0 and ignore writes):
  - addr0 MASK: rw, 1 = enabled.
  - addr1 MODE: rw, 1 = edge.
  - addr2 PENDING: read returns r; write-1-to-clear applies to edge-mode bits only.
  - addr3 STATUS: read-only, {22'b0, irq_id_valid, state[1:0], irq_id padded to 7 bits}.
- Register writes take effect on the next cycle.
- FSM, all registered; state encoding IDLE=0, REQ=1, SERVICE=2:
  - IDLE: if |e, go to REQ next cycle. ir_out=0. ack and eoi ignored.
  - REQ: ir_out=1.
    - ack=1 and |e: latch irq_id=winner, set irq_id_valid=1, clear PENDING[winner] if edge-mode, go to SERVICE.
    - ack=1 and e=0: go to IDLE; irq_id_valid stays 0.
    - ack=0 and e=0 (source withdrawn or masked): go to IDLE.
  - SERVICE: ir_out=0. New requests stay pending; no nesting. On eoi: irq_id_valid=0, go to IDLE. A request present at that point re-raises ir_out after IDLE->REQ, i.e. 2 cycles after eoi.
- Latency: a synchronised request in IDLE asserts ir_out 2 cycles after e rises; irq_in to ir_out is SYNC_STAGES+2 cycles for level mode and SYNC_STAGES+3 for edge mode (one extra for the PENDING set).
- Simultaneous events:
  - Edge set and W1C clear on the same bit in the same cycle: set wins.
  - Edge set and ack-clear on the same bit in the same cycle: set wins.
  - ack and eoi together: handled by the current state only.
  - Mid-operation reset: everything returns to reset values immediately; the in-service channel is lost.

Test Plan:
- Reset: hold rst=0 with irq_in=8'hFF -> ir_out=0, cfg_dout=0 at all four addresses, STATUS state=0.
- Level priority: MASK=8'h28, MODE=0, irq_in=8'h28 -> ir_out=1 at SYNC_STAGES+2 cycles; ack -> irq_id=3, irq_id_valid=1, ir_out=0; eoi with source still high -> ir_out re-asserts 2 cycles later, ack -> irq_id=3.
- Edge latch: MODE=MASK=8'h01, pulse irq_in[0] for 3 cycles -> PENDING reads 1 and stays 1 after the pulse; ack -> PENDING reads 0, irq_id=0; eoi -> IDLE, ir_out stays 0.
- Withdrawal: level channel 2 enabled, in REQ clear MASK to 0 -> next cycle ir_out=0, state IDLE; a later ack -> irq_id_valid stays 0.
- Collision: edge channel 1 PENDING=1; W1C write 32'h2 in the same cycle a new edge sets bit 1 -> PENDING[1] reads 1.
- Async reset mid-service: in SERVICE with irq_id=4, pulse rst=0 between clock edges -> irq_id_valid=0, ir_out=0 and MASK=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: multi-source interrupt controller feeding the CP0 external
// interrupt input. Sources are synchronised, qualified per channel as level
// or edge, masked, and arbitrated by fixed priority (lowest index wins).
// An ack/EOI handshake tracks the in-service channel. Software configures
// the block through a small word-addressed register port.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no request presented; waits for a qualified enabled request
// REQ     | ir_out high; waits for ack, or drops back if request vanishes
// SERVICE | channel in service; new requests stay pending until eoi
module irq_ctrl #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] irq_in,
    output logic            ir_out,
    input  logic            ack,
    input  logic            eoi,
    output logic [ID_W-1:0] irq_id,
    output logic            irq_id_valid,
    input  logic            cfg_wen,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_din,
    output logic [31:0]     cfg_dout
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] mask_q, mask_d;
    logic [N_CH-1:0] mode_q, mode_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [ID_W-1:0] irq_id_q, irq_id_d;
    logic            valid_q, valid_d;
    logic            any_q;

    logic [N_CH-1:0] sync_s;
    logic [N_CH-1:0] req_raw;
    logic [N_CH-1:0] req_en;
    logic [N_CH-1:0] win_oh;
    logic [N_CH-1:0] clr_w;
    logic [ID_W-1:0] win_id;
    logic            ack_take;
    logic            wr_mask, wr_mode, wr_pend;
    logic            unused_din;

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign req_raw = (mode_q & pending_q) | (~mode_q & sync_s);
    assign req_en  = req_raw & mask_q;

    assign wr_mask = cfg_wen && (cfg_addr == 2'd0);
    assign wr_mode = cfg_wen && (cfg_addr == 2'd1);
    assign wr_pend = cfg_wen && (cfg_addr == 2'd2);

    // Bits above N_CH of the write data have no backing register.
    assign unused_din = ^cfg_din;

    // Input synchroniser chain plus one cycle of edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev_q <= sync_s;
        end
    end

    // Fixed-priority pick: scan downwards so the lowest set index is kept.
    always_comb begin
        win_id = '0;
        win_oh = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_en[i]) begin
                win_id    = ID_W'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    // Next-state logic; the one-cycle any_q stage qualifies a request before IDLE leaves.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        valid_d  = valid_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_q) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (|req_en) begin
                    if (ack) begin
                        state_d  = ST_SERVICE;
                        irq_id_d = win_id;
                        valid_d  = 1'b1;
                        ack_take = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Config and pending next values; a fresh edge beats both clears, level bits hold nothing.
    always_comb begin
        mask_d = wr_mask ? cfg_din[N_CH-1:0] : mask_q;
        mode_d = wr_mode ? cfg_din[N_CH-1:0] : mode_q;
        clr_w  = '0;
        if (wr_pend)  clr_w = clr_w | cfg_din[N_CH-1:0];
        if (ack_take) clr_w = clr_w | win_oh;
        pending_d = ((pending_q & ~clr_w) | (sync_s & ~prev_q)) & mode_q;
    end

    // Control state, configuration and in-service tracking registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            irq_id_q  <= '0;
            valid_q   <= 1'b0;
            any_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            irq_id_q  <= irq_id_d;
            valid_q   <= valid_d;
            any_q     <= |req_en;
        end
    end

    // Register read mux; PENDING shows the live raw request vector.
    always_comb begin
        cfg_dout = '0;
        case (cfg_addr)
            2'd0:    cfg_dout = 32'(mask_q);
            2'd1:    cfg_dout = 32'(mode_q);
            2'd2:    cfg_dout = 32'(req_raw);
            default: cfg_dout = {22'd0, valid_q, state_q, 7'(irq_id_q)};
        endcase
    end

    assign ir_out       = (state_q == ST_REQ);
    assign irq_id       = irq_id_q;
    assign irq_id_valid = valid_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios with literal expectations plus
// a per-cycle comparison against a behavioural model of the controller.
module tb_irq_ctrl;
    localparam int N_CH = 8;
    localparam int SS   = 2;
    localparam int ID_W = 5;
    localparam int IDLE = 0;
    localparam int REQ  = 1;
    localparam int SERV = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N_CH-1:0] irq_in = '1;
    logic            ir_out;
    logic            ack = 1'b0;
    logic            eoi = 1'b0;
    logic [ID_W-1:0] irq_id;
    logic            irq_id_valid;
    logic            cfg_wen = 1'b0;
    logic [1:0]      cfg_addr = 2'd0;
    logic [31:0]     cfg_din = 32'd0;
    logic [31:0]     cfg_dout;

    int n_checks = 0;
    int n_errors = 0;

    irq_ctrl #(.N_CH(N_CH), .SYNC_STAGES(SS), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .ir_out(ir_out),
        .ack(ack), .eoi(eoi), .irq_id(irq_id), .irq_id_valid(irq_id_valid),
        .cfg_wen(cfg_wen), .cfg_addr(cfg_addr), .cfg_din(cfg_din),
        .cfg_dout(cfg_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_hist[k] is irq_in as sampled k+1 clock edges ago.
    logic [N_CH-1:0] m_hist [0:SS];
    logic [N_CH-1:0] m_mask, m_mode, m_pend;
    int              m_state, m_id;
    bit              m_valid, m_seen;

    function automatic int lowest(input logic [N_CH-1:0] v);
        for (int i = 0; i < N_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_dout(input logic [1:0] a);
        logic [N_CH-1:0] s;
        s = m_hist[SS-1];
        case (a)
            2'd0:    return 32'(m_mask);
            2'd1:    return 32'(m_mode);
            2'd2:    return 32'((m_pend & m_mode) | (s & ~m_mode));
            default: return {22'd0, m_valid, 2'(m_state), 7'(m_id)};
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin : model
        logic [N_CH-1:0] s, p, e, np;
        int w, ns, nid;
        bit nv;
        if (!rst) begin
            for (int k = 0; k <= SS; k++) m_hist[k] <= '0;
            m_mask <= '0; m_mode <= '0; m_pend <= '0;
            m_state <= IDLE; m_id <= 0; m_valid <= 1'b0; m_seen <= 1'b0;
        end else begin
            s   = m_hist[SS-1];
            p   = m_hist[SS];
            e   = ((m_pend & m_mode) | (s & ~m_mode)) & m_mask;
            w   = lowest(e);
            ns  = m_state; nid = m_id; nv = m_valid; np = m_pend;
            if (cfg_wen && cfg_addr == 2'd2) np = np & ~cfg_din[N_CH-1:0];
            case (m_state)
                IDLE: if (m_seen) ns = REQ;
                REQ: begin
                    if (w < 0) ns = IDLE;
                    else if (ack) begin
                        ns = SERV; nid = w; nv = 1'b1; np[w] = 1'b0;
                    end
                end
                SERV: if (eoi) begin ns = IDLE; nv = 1'b0; end
                default: ns = IDLE;
            endcase
            np = (np | (s & ~p)) & m_mode;
            m_pend  <= np;
            m_state <= ns; m_id <= nid; m_valid <= nv;
            m_seen  <= (e != '0);
            if (cfg_wen && cfg_addr == 2'd0) m_mask <= cfg_din[N_CH-1:0];
            if (cfg_wen && cfg_addr == 2'd1) m_mode <= cfg_din[N_CH-1:0];
            m_hist[0] <= irq_in;
            for (int k = 1; k <= SS; k++) m_hist[k] <= m_hist[k-1];
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_ir_out", 32'(ir_out), 32'(m_state == REQ));
        check("cyc_irq_id", 32'(irq_id), 32'(m_id));
        check("cyc_valid", 32'(irq_id_valid), 32'(m_valid));
        check("cyc_cfg_dout", cfg_dout, m_dout(cfg_addr));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_wen = 1'b1; cfg_addr = a; cfg_din = d;
        tick();
        cfg_wen = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic wait_ir(output int n);
        n = 0;
        while (ir_out !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic rd(input logic [1:0] a, input string name, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        check(name, cfg_dout, exp);
    endtask

    initial begin
        int n;
        // Reset held with all sources high.
        repeat (3) tick();
        check("rst_ir_out", 32'(ir_out), 32'd0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = a[1:0];
            #1;
            check("rst_dout", cfg_dout, 32'd0);
        end
        check("rst_state", 32'(cfg_dout[8:7]), 32'd0);
        irq_in = '0;
        tick();
        rst = 1'b1;
        repeat (4) tick();

        // Level priority.
        wr(2'd0, 32'h28);
        wr(2'd1, 32'h00);
        irq_in = 8'h28;
        wait_ir(n);
        check("level_latency", 32'(n), 32'(SS + 2));
        pulse_ack();
        check("level_id", 32'(irq_id), 32'd3);
        check("level_valid", 32'(irq_id_valid), 32'd1);
        check("level_ir_low", 32'(ir_out), 32'd0);
        repeat (3) tick();
        check("service_no_nest", 32'(ir_out), 32'd0);
        pulse_eoi();
        wait_ir(n);
        check("eoi_reraise", 32'(n + 1), 32'd2);
        pulse_ack();
        check("level_id2", 32'(irq_id), 32'd3);
        wr(2'd0, 32'h00);
        irq_in = '0;
        repeat (3) tick();
        pulse_eoi();
        repeat (3) tick();
        check("level_done", 32'(ir_out), 32'd0);

        // Edge latch.
        wr(2'd1, 32'h01);
        wr(2'd0, 32'h01);
        irq_in = 8'h01;
        repeat (3) tick();
        irq_in = '0;
        rd(2'd2, "edge_pend_set", 32'h1);
        wait_ir(n);
        check("edge_latency", 32'(n + 3), 32'(SS + 3));
        repeat (2) tick();
        rd(2'd2, "edge_pend_hold", 32'h1);
        check("edge_req_hold", 32'(ir_out), 32'd1);
        pulse_ack();
        rd(2'd2, "edge_pend_clr", 32'h0);
        check("edge_id", 32'(irq_id), 32'd0);
        check("edge_valid", 32'(irq_id_valid), 32'd1);
        pulse_eoi();
        repeat (4) tick();
        check("edge_idle_ir", 32'(ir_out), 32'd0);
        rd(2'd3, "edge_idle_state", 32'd0);

        // Withdrawal of a level request while in REQ.
        wr(2'd1, 32'h00);
        wr(2'd0, 32'h04);
        irq_in = 8'h04;
        wait_ir(n);
        check("wd_latency", 32'(n), 32'(SS + 2));
        wr(2'd0, 32'h00);
        check("wd_hold", 32'(ir_out), 32'd1);
        tick();
        check("wd_ir_low", 32'(ir_out), 32'd0);
        rd(2'd3, "wd_state", {22'd0, 1'b0, 2'd0, 7'd0});
        pulse_ack();
        check("wd_valid", 32'(irq_id_valid), 32'd0);
        irq_in = '0;
        repeat (3) tick();

        // Edge set colliding with a W1C clear on the same bit.
        wr(2'd1, 32'h02);
        irq_in = 8'h02;
        repeat (4) tick();
        irq_in = '0;
        repeat (4) tick();
        rd(2'd2, "col_pend_pre", 32'h2);
        irq_in = 8'h02;
        repeat (2) tick();
        wr(2'd2, 32'h2);
        rd(2'd2, "col_set_wins", 32'h2);
        wr(2'd2, 32'h2);
        rd(2'd2, "w1c_clears", 32'h0);
        irq_in = '0;
        repeat (3) tick();

        // Asynchronous reset during service.
        wr(2'd1, 32'h00);
        wr(2'd0, 32'h10);
        irq_in = 8'h10;
        wait_ir(n);
        check("ar_latency", 32'(n), 32'(SS + 2));
        pulse_ack();
        check("ar_id", 32'(irq_id), 32'd4);
        check("ar_valid", 32'(irq_id_valid), 32'd1);
        cfg_addr = 2'd0;
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid_clr", 32'(irq_id_valid), 32'd0);
        check("ar_ir_out", 32'(ir_out), 32'd0);
        check("ar_id_clr", 32'(irq_id), 32'd0);
        check("ar_mask_clr", cfg_dout, 32'd0);
        tick();
        #2;
        rst = 1'b1;
        repeat (6) tick();
        check("ar_after", 32'(ir_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
